// File: rtl/night_phase_sequencer_if.sv
// Handshake bundle between the night-mode sequencer and its output stage.
// Ports: ew_request/flash_mode (sensor and mode requests into the sequencer),
//        lane_output/load_time/phase/phase_done (light codes and phase timing out).
interface night_phase_sequencer_if #(
  parameter int TIME_W = 7
);
  logic              ew_request;
  logic              flash_mode;
  logic [7:0]        lane_output;
  logic [TIME_W-1:0] load_time;
  logic [2:0]        phase;
  logic              phase_done;

  // master drives the requests and observes the lights; slave is the sequencer
  modport master (
    output ew_request, flash_mode,
    input  lane_output, load_time, phase, phase_done
  );

  modport slave (
    input  ew_request, flash_mode,
    output lane_output, load_time, phase, phase_done
  );
endinterface

// File: rtl/night_phase_sequencer.sv
// Night-mode junction sequencer: main road (N+S) rests green, side road (E+W)
// served on sensor demand through yellow and all-red clearance; optional flashing mode.
// Latency: lane_output/load_time/phase are Moore (registered state); phase_done is
//          combinational from state, counter and the live request inputs. No backpressure.
// Ports: clk, rst (async, active-high); bus (slave modport) carries ew_request,
//        flash_mode in and lane_output {WW,SS,EE,NN}, load_time, phase, phase_done out.
module night_phase_sequencer #(
  parameter int GREEN_MIN   = 20,
  parameter int GREEN_MAX   = 60,
  parameter int YELLOW_TIME = 4,
  parameter int ALLRED_TIME = 2,
  parameter int FLASH_HALF  = 8,
  parameter int TIME_W      = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  night_phase_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_NS = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_EW = 3'd5,
    FLASH     = 3'd6
  } phase_t;

  // per-direction light codes
  localparam logic [1:0] C_GREEN  = 2'b11;
  localparam logic [1:0] C_YELLOW = 2'b01;
  localparam logic [1:0] C_RED    = 2'b00;
  localparam logic [1:0] C_DARK   = 2'b10;

  // last counter value of each timed phase
  localparam logic [TIME_W-1:0] GMIN_LAST  = TIME_W'(GREEN_MIN - 1);
  localparam logic [TIME_W-1:0] GMAX_LAST  = TIME_W'(GREEN_MAX - 1);
  localparam logic [TIME_W-1:0] YEL_LAST   = TIME_W'(YELLOW_TIME - 1);
  localparam logic [TIME_W-1:0] AR_LAST    = TIME_W'(ALLRED_TIME - 1);
  localparam logic [TIME_W-1:0] FLASH_LAST = TIME_W'(FLASH_HALF - 1);

  phase_t            state, state_nxt;
  logic [TIME_W-1:0] cnt, cnt_nxt;
  logic              req_latch, req_latch_nxt;
  logic              flash_on, flash_on_nxt;
  logic              req;
  logic              done;
  logic [1:0]        ns_code, ew_code;

  assign req = req_latch | bus.ew_request;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ALLRED_EW;
      cnt       <= '0;
      req_latch <= 1'b0;
      flash_on  <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_latch <= req_latch_nxt;
      flash_on  <= flash_on_nxt;
    end
  end

  // next-state logic; done is the exit (or half-period end) condition of the phase
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      NS_GREEN: begin
        done = ((cnt >= GMIN_LAST) && req) || (cnt == GMAX_LAST);
        if (done) state_nxt = NS_YELLOW;
      end
      NS_YELLOW: begin
        done = (cnt == YEL_LAST);
        if (done) state_nxt = ALLRED_NS;
      end
      ALLRED_NS: begin
        done = (cnt == AR_LAST);
        if (done) state_nxt = bus.flash_mode ? FLASH : EW_GREEN;
      end
      EW_GREEN: begin
        done = (cnt == GMIN_LAST);
        if (done) state_nxt = EW_YELLOW;
      end
      EW_YELLOW: begin
        done = (cnt == YEL_LAST);
        if (done) state_nxt = ALLRED_EW;
      end
      ALLRED_EW: begin
        done = (cnt == AR_LAST);
        if (done) state_nxt = bus.flash_mode ? FLASH : NS_GREEN;
      end
      FLASH: begin
        // leaving flash is immediate; done only marks the half-period boundary
        done = (cnt == FLASH_LAST);
        if (!bus.flash_mode) state_nxt = ALLRED_EW;
      end
      default: state_nxt = ALLRED_EW;
    endcase
  end

  // counter, flash half and side-demand latch updates
  always_comb begin
    cnt_nxt       = cnt + TIME_W'(1);
    flash_on_nxt  = flash_on;
    req_latch_nxt = req_latch;

    // clear on any phase change, and on each flash half-period wrap
    if ((state_nxt != state) || done) cnt_nxt = '0;

    if ((state_nxt == FLASH) && (state != FLASH))
      flash_on_nxt = 1'b1;
    else if ((state == FLASH) && done)
      flash_on_nxt = ~flash_on;

    // entering EW_GREEN serves the demand; clear wins over a same-cycle set
    if ((state_nxt == EW_GREEN) && (state != EW_GREEN))
      req_latch_nxt = 1'b0;
    else if (bus.ew_request && (state != EW_GREEN))
      req_latch_nxt = 1'b1;
  end

  // output decode from registered state only
  always_comb begin
    ns_code       = C_RED;
    ew_code       = C_RED;
    bus.load_time = TIME_W'(ALLRED_TIME);
    case (state)
      NS_GREEN:  begin ns_code = C_GREEN;  bus.load_time = TIME_W'(GREEN_MAX);   end
      NS_YELLOW: begin ns_code = C_YELLOW; bus.load_time = TIME_W'(YELLOW_TIME); end
      EW_GREEN:  begin ew_code = C_GREEN;  bus.load_time = TIME_W'(GREEN_MIN);   end
      EW_YELLOW: begin ew_code = C_YELLOW; bus.load_time = TIME_W'(YELLOW_TIME); end
      FLASH: begin
        bus.load_time = TIME_W'(FLASH_HALF);
        ns_code       = flash_on ? C_YELLOW : C_DARK;
        ew_code       = flash_on ? C_RED    : C_DARK;
      end
      default: ;
    endcase
    bus.lane_output = {ew_code, ns_code, ew_code, ns_code};
  end

  assign bus.phase      = state;
  assign bus.phase_done = done;

endmodule

// File: tb/tb_night_phase_sequencer.sv
module tb_night_phase_sequencer;

  localparam int GMIN = 20;
  localparam int GMAX = 60;
  localparam int YEL  = 4;
  localparam int AR   = 2;
  localparam int FH   = 8;
  localparam int TW   = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  night_phase_sequencer_if #(.TIME_W(TW)) bus ();

  night_phase_sequencer #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_TIME(YEL),
    .ALLRED_TIME(AR), .FLASH_HALF(FH), .TIME_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int scn   = 0;

  // reference model: phase number, cycles spent in it, pending side demand, flash lamp on
  int m_ph;
  int m_t;
  bit m_dem;
  bit m_lit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s scn=%0d cyc=%0d got=%0h exp=%0h", tag, scn, cyc, got, exp);
    end
  endtask

  function automatic int ph_len(input int ph);
    case (ph)
      0: return GMAX;
      1, 4: return YEL;
      3: return GMIN;
      6: return FH;
      default: return AR;
    endcase
  endfunction

  function automatic logic [7:0] ph_lanes(input int ph, input bit lit);
    logic [1:0] ns, ew;
    ns = 2'b00; ew = 2'b00;
    case (ph)
      0: ns = 2'b11;
      1: ns = 2'b01;
      3: ew = 2'b11;
      4: ew = 2'b01;
      6: begin ns = lit ? 2'b01 : 2'b10; ew = lit ? 2'b00 : 2'b10; end
      default: ;
    endcase
    return {ew, ns, ew, ns};
  endfunction

  function automatic bit m_exit(input bit ew);
    if (m_ph == 0) return ((m_t >= GMIN - 1) && (m_dem || ew)) || (m_t == GMAX - 1);
    return m_t == ph_len(m_ph) - 1;
  endfunction

  task automatic model_reset();
    m_ph = 5; m_t = 0; m_dem = 0; m_lit = 1;
  endtask

  task automatic model_step(input bit ew, input bit fl);
    bit ex;
    int nph;
    ex  = m_exit(ew);
    nph = m_ph;
    if (m_ph == 6) nph = fl ? 6 : 5;
    else if (ex) begin
      case (m_ph)
        2: nph = fl ? 6 : 3;
        5: nph = fl ? 6 : 0;
        default: nph = m_ph + 1;
      endcase
    end
    if (ew && m_ph != 3) m_dem = 1;
    if (nph == 3 && m_ph != 3) m_dem = 0;
    if (nph != m_ph) begin m_t = 0; m_lit = 1; end
    else if (m_ph == 6 && ex) begin m_t = 0; m_lit = !m_lit; end
    else m_t++;
    m_ph = nph;
  endtask

  // constant expectations taken straight from the worked timelines
  task automatic spot_checks();
    case (scn)
      1: begin
        if (cyc == 2)   chk("s1_ns_green", bus.phase, 0);
        if (cyc == 2)   chk("s1_lane33", bus.lane_output, 8'h33);
        if (cyc == 62)  chk("s1_ns_yel", bus.lane_output, 8'h11);
        if (cyc == 66)  chk("s1_allred", bus.lane_output, 8'h00);
        if (cyc == 68)  chk("s1_ew_green", bus.lane_output, 8'hCC);
        if (cyc == 88)  chk("s1_ew_yel", bus.lane_output, 8'h44);
        if (cyc == 92)  chk("s1_allred_ew", bus.phase, 5);
        if (cyc == 94)  chk("s1_ns_again", bus.phase, 0);
        if (cyc == 153) chk("s6_full_green", bus.phase, 0);
        if (cyc == 154) chk("s6_yel_after60", bus.phase, 1);
      end
      2: begin
        if (cyc == 21) chk("s2_done", bus.phase_done, 1);
        if (cyc == 21) chk("s2_still_grn", bus.phase, 0);
        if (cyc == 22) chk("s2_yellow", bus.phase, 1);
      end
      3: begin
        if (cyc == 40)  chk("s3_grn", bus.phase, 0);
        if (cyc == 41)  chk("s3_yellow", bus.phase, 1);
        if (cyc == 132) chk("s3_latch_clr", bus.phase, 0);
        if (cyc == 133) chk("s3_yel2", bus.phase, 1);
      end
      4: begin
        if (cyc == 61) chk("s4_grn_end", bus.phase, 0);
        if (cyc == 68) chk("s4_flash", bus.phase, 6);
        if (cyc == 68) chk("s4_lt_fh", bus.load_time, FH);
        if (cyc == 75) chk("s4_on_end", bus.lane_output, 8'h11);
        if (cyc == 75) chk("s4_half_done", bus.phase_done, 1);
        if (cyc == 76) chk("s4_off", bus.lane_output, 8'hAA);
        if (cyc == 84) chk("s4_on2", bus.lane_output, 8'h11);
        if (cyc == 86) chk("s4_allred_ew", bus.phase, 5);
        if (cyc == 88) chk("s4_ns_green", bus.phase, 0);
      end
      default: ;
    endcase
  endtask

  // drive inputs at the falling edge, check mid-cycle, advance the model at the rising edge
  task automatic run_cycle(input bit ew, input bit fl);
    bus.ew_request = ew;
    bus.flash_mode = fl;
    #1;
    chk("phase", bus.phase, m_ph);
    chk("lane", bus.lane_output, ph_lanes(m_ph, m_lit));
    chk("load_time", bus.load_time, ph_len(m_ph));
    chk("phase_done", bus.phase_done, m_exit(ew));
    spot_checks();
    @(posedge clk);
    model_step(ew, fl);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    bus.ew_request = 1'b0;
    bus.flash_mode = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  initial begin
    bit ew, fl;
    bus.ew_request = 1'b0;
    bus.flash_mode = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_lane", bus.lane_output, 8'h00);
    chk("rst_phase", bus.phase, 5);
    chk("rst_load", bus.load_time, AR);
    chk("rst_done", bus.phase_done, 0);

    // 1 + 6: no demand, ew_request held only while EW is green
    scn = 1; do_reset();
    for (int i = 0; i < 160; i++) run_cycle(cyc >= 68 && cyc <= 87, 1'b0);

    // 2: short pulse early in NS green
    scn = 2; do_reset();
    for (int i = 0; i < 40; i++) run_cycle(cyc == 5, 1'b0);

    // 3: pulse after minimum green
    scn = 3; do_reset();
    for (int i = 0; i < 140; i++) run_cycle(cyc == 40, 1'b0);

    // 4: flashing mode request and release
    scn = 4; do_reset();
    for (int i = 0; i < 100; i++) run_cycle(1'b0, cyc >= 10 && cyc < 85);

    // 5: async reset while EW is green
    scn = 5; do_reset();
    for (int i = 0; i < 76; i++) run_cycle(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_lane", bus.lane_output, 8'h00);
    chk("arst_phase", bus.phase, 5);
    chk("arst_load", bus.load_time, AR);
    chk("arst_done", bus.phase_done, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
    for (int i = 0; i < 100; i++) run_cycle(1'b0, 1'b0);

    // randomized traffic with occasional flash sessions and held requests
    scn = 7; do_reset();
    fl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) fl = !fl;
      if ($urandom_range(0, 3) == 0) ew = ($urandom_range(0, 24) == 0);
      else ew = 1'b0;
      if ($urandom_range(0, 299) == 0) ew = 1'b1;
      run_cycle(ew, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
